pipeline_stall_ctrl: RTL

// - Consumer side of hazard_detected: turns ID-stage hazard flags, EXE-stage branch resolution
//   and MEM-stage data-memory handshake into per-stage freeze/bubble/flush controls.
// - Sits beside the pipeline registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB) in the core top.
// - Owns the multi-cycle memory-wait FSM, the memory-timeout halt and saturating stall/flush counters.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 10 +
 rtl/pipeline_stall_ctrl_if.sv | 28 ++
 rtl/pipeline_stall_ctrl_sat_counter.sv | 22 ++
 rtl/pipeline_stall_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and default sizing for the pipeline stall controller.
package pipeline_pkg;

    typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_HALT} stall_state_t;

    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned MEM_TIMEOUT_DEF = 255;
    localparam int unsigned TO_W_DEF        = 8;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/branch/memory status into the stall controller and per-stage controls out of it.
interface pipeline_stall_ctrl_if;

    logic hazard_detected;
    logic branch_taken;
    logic mem_req;
    logic mem_ack;

    logic pc_freeze;
    logic IF_ID_freeze;
    logic IF_ID_flush;
    logic ID_EXE_bubble;
    logic EXE_MEM_freeze;
    logic MEM_WB_bubble;

    modport master (
        output hazard_detected, branch_taken, mem_req, mem_ack,
        input  pc_freeze, IF_ID_freeze, IF_ID_flush, ID_EXE_bubble,
               EXE_MEM_freeze, MEM_WB_bubble
    );

    modport slave (
        input  hazard_detected, branch_taken, mem_req, mem_ack,
        output pc_freeze, IF_ID_freeze, IF_ID_flush, ID_EXE_bubble,
               EXE_MEM_freeze, MEM_WB_bubble
    );

endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Turns ID hazards, EXE branch resolution and MEM handshake into per-stage
// freeze/bubble/flush controls; owns the memory-wait FSM and stall/flush counters.
module pipeline_stall_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned TO_W        = TO_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_stall_ctrl_if.slave  ctl,
    input  logic                  cnt_clr,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    stall_state_t    state, state_nxt;
    logic [TO_W-1:0] wait_cnt, wait_nxt;

    logic pc_frz, ifid_frz, ifid_fl, idexe_bub, exemem_frz, memwb_bub, halt_q;
    logic mem_hold, advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        wait_nxt   = wait_cnt;
        mem_hold   = 1'b0;
        advance    = 1'b0;
        halt_q     = 1'b0;
        pc_frz     = 1'b0;
        ifid_frz   = 1'b0;
        ifid_fl    = 1'b0;
        idexe_bub  = 1'b0;
        exemem_frz = 1'b0;
        memwb_bub  = 1'b0;

        case (state)
            ST_RUN: begin
                if (ctl.mem_req && !ctl.mem_ack) begin
                    mem_hold  = 1'b1;
                    state_nxt = ST_MEM_WAIT;
                    wait_nxt  = TO_W'(1);
                end else begin
                    advance = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!ctl.mem_ack) begin
                    mem_hold = 1'b1;
                    wait_nxt = wait_cnt + TO_W'(1);
                    if (wait_cnt == TO_W'(MEM_TIMEOUT)) begin
                        state_nxt = ST_HALT;
                    end
                end else begin
                    advance   = 1'b1;
                    state_nxt = ST_RUN;
                    wait_nxt  = '0;
                end
            end
            ST_HALT: begin
                mem_hold = 1'b1;
                halt_q   = 1'b1;
            end
            default: begin
                state_nxt = ST_RUN;
                wait_nxt  = '0;
            end
        endcase

        // Memory hold and halt freeze the front end and drain MEM/WB with NOPs.
        if (mem_hold) begin
            pc_frz     = 1'b1;
            ifid_frz   = 1'b1;
            exemem_frz = 1'b1;
            memwb_bub  = 1'b1;
        end else if (advance) begin
            if (ctl.branch_taken) begin
                ifid_fl   = 1'b1;
                idexe_bub = 1'b1;
            end else if (ctl.hazard_detected) begin
                pc_frz    = 1'b1;
                ifid_frz  = 1'b1;
                idexe_bub = 1'b1;
            end
        end
    end

    // Controls are combinational, so they are gated to keep them low while reset is held.
    assign ctl.pc_freeze      = rst_n & pc_frz;
    assign ctl.IF_ID_freeze   = rst_n & ifid_frz;
    assign ctl.IF_ID_flush    = rst_n & ifid_fl;
    assign ctl.ID_EXE_bubble  = rst_n & idexe_bub;
    assign ctl.EXE_MEM_freeze = rst_n & exemem_frz;
    assign ctl.MEM_WB_bubble  = rst_n & memwb_bub;
    assign halted             = rst_n & halt_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (pc_frz),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (ifid_fl),
        .q     (flush_cnt)
    );

endmodule
